// File: rtl/rbot_moves_pkg.sv
// Shared move-code definitions for the robot move path.
// Move codes 2..13 are real moves; 0 is an empty slot, 1/14/15 are invalid.
package rbot_moves_pkg;
    localparam int MOVE_W          = 4;
    localparam int MOVES_PER_BATCH = 50;
    localparam int BATCH_W         = MOVE_W * MOVES_PER_BATCH;

    localparam logic [MOVE_W-1:0] MOVE_NONE = 4'd0;
    localparam logic [MOVE_W-1:0] MOVE_R    = 4'd2;
    localparam logic [MOVE_W-1:0] MOVE_RI   = 4'd3;
    localparam logic [MOVE_W-1:0] MOVE_U    = 4'd4;
    localparam logic [MOVE_W-1:0] MOVE_UI   = 4'd5;
    localparam logic [MOVE_W-1:0] MOVE_F    = 4'd6;
    localparam logic [MOVE_W-1:0] MOVE_FI   = 4'd7;
    localparam logic [MOVE_W-1:0] MOVE_L    = 4'd8;
    localparam logic [MOVE_W-1:0] MOVE_LI   = 4'd9;
    localparam logic [MOVE_W-1:0] MOVE_B    = 4'd10;
    localparam logic [MOVE_W-1:0] MOVE_BI   = 4'd11;
    localparam logic [MOVE_W-1:0] MOVE_D    = 4'd12;
    localparam logic [MOVE_W-1:0] MOVE_DI   = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_BLANK, S_WAIT_DONE, S_SETTLE, S_FAULT
    } disp_state_t;

    function automatic logic is_valid_move(input logic [MOVE_W-1:0] code);
        return (code >= MOVE_R) && (code <= MOVE_DI);
    endfunction
endpackage

// File: rtl/move_fifo.sv
// Synchronous move FIFO with occupancy count and combinational head.
module move_fifo
    import rbot_moves_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [MOVE_W-1:0] data,
    input  logic              pop,
    output logic [MOVE_W-1:0] head,
    output logic [CW-1:0]     count
);
    logic [MOVE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/move_arbiter.sv
// Buffers solver move batches, arbitrates them against manual jogs and
// drives the stepper start/done handshake with settle delay and watchdog.
module move_arbiter
    import rbot_moves_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 25000,
    parameter int TIMEOUT_CYCLES = 25000000,
    parameter int DEPTH          = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               batch_valid,
    input  logic [BATCH_W-1:0] batch_moves,
    output logic               batch_ready,
    input  logic               man_req,
    input  logic [MOVE_W-1:0]  man_move,
    output logic               man_ack,
    input  logic               pause,
    output logic [MOVE_W-1:0]  next_move,
    output logic               move_start,
    input  logic               move_done,
    output logic [6:0]         queue_count,
    output logic [7:0]         moves_done_count,
    output logic               busy,
    output logic               fault
);
    localparam int CW = $clog2(DEPTH) + 1;

    disp_state_t       state;
    logic [BATCH_W-1:0] scan_sr;
    logic [5:0]        scan_left;
    logic [31:0]       timer;
    logic [MOVE_W-1:0] scan_code, head;
    logic [CW-1:0]     count;
    logic              loading, push, pop, last_manual;
    logic              q_cand, m_cand, pick_q, pick_m;

    // Loader: shift the latched batch out MSB-first, one nibble per cycle.
    assign loading     = (scan_left != '0);
    assign scan_code   = scan_sr[BATCH_W-1 -: MOVE_W];
    assign push        = loading && is_valid_move(scan_code);
    assign batch_ready = !loading && (count <= CW'(DEPTH - MOVES_PER_BATCH));
    assign queue_count = 7'(count);

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_sr   <= '0;
            scan_left <= '0;
        end else if (batch_valid && batch_ready) begin
            scan_sr   <= batch_moves;
            scan_left <= 6'(MOVES_PER_BATCH);
        end else if (loading) begin
            scan_sr   <= scan_sr << MOVE_W;
            scan_left <= scan_left - 6'd1;
        end
    end

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .data  (scan_code),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    // A high man_ack means the request was consumed last cycle; the requester
    // has not dropped it yet, so it must not be served twice.
    assign q_cand = (state == S_IDLE) && (count != '0) && !pause;
    assign m_cand = (state == S_IDLE) && man_req && !man_ack;
    assign pick_q = q_cand && (!m_cand || last_manual);
    assign pick_m = m_cand && !pick_q;
    assign pop    = pick_q;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            next_move        <= MOVE_NONE;
            move_start       <= 1'b0;
            man_ack          <= 1'b0;
            fault            <= 1'b0;
            moves_done_count <= '0;
            timer            <= '0;
            last_manual      <= 1'b1;
        end else begin
            move_start <= 1'b0;
            man_ack    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_q) begin
                        next_move   <= head;
                        move_start  <= 1'b1;
                        last_manual <= 1'b0;
                        state       <= S_ISSUE;
                    end else if (pick_m) begin
                        man_ack     <= 1'b1;
                        last_manual <= 1'b1;
                        if (is_valid_move(man_move)) begin
                            next_move  <= man_move;
                            move_start <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_BLANK;
                end
                S_BLANK: begin
                    if (timer == 32'd1) begin
                        timer <= '0;
                        state <= S_WAIT_DONE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (move_done) begin
                        moves_done_count <= moves_done_count + 8'd1;
                        timer            <= '0;
                        state            <= S_SETTLE;
                    end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (timer == 32'(SETTLE_CYCLES - 1)) state <= S_IDLE;
                    else                                 timer <= timer + 32'd1;
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter: reset/table checks, directed corner sequences and
// randomized batches/jogs compared against a queue-based expected move stream.
module tb_move_arbiter;
    import rbot_moves_pkg::*;

    localparam int SETTLE   = 5;
    localparam int TIMEOUT  = 100;
    localparam int DEPTH    = 64;
    localparam int DONE_LAT = 10;
    localparam int GAP      = 5 + SETTLE;

    logic               clock = 1'b0, reset = 1'b1;
    logic               batch_valid = 1'b0, batch_ready;
    logic [BATCH_W-1:0] batch_moves = '0;
    logic               man_req = 1'b0, man_ack, pause = 1'b0;
    logic [MOVE_W-1:0]  man_move = '0, next_move;
    logic               move_start, move_done = 1'b1, busy, fault;
    logic [6:0]         queue_count;
    logic [7:0]         moves_done_count;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int man_posted = 0, stall_done = 0, done_lat = DONE_LAT;
    int ack_cnt = 0, ack_with_start = 0, done_cnt = 0;
    int last_start = -1, min_gap = 1 << 30, fault_cyc = -1;
    logic [MOVE_W-1:0] starts[$];

    move_arbiter #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .batch_valid(batch_valid), .batch_moves(batch_moves),
        .batch_ready(batch_ready), .man_req(man_req), .man_move(man_move), .man_ack(man_ack),
        .pause(pause), .next_move(next_move), .move_start(move_start), .move_done(move_done),
        .queue_count(queue_count), .moves_done_count(moves_done_count), .busy(busy), .fault(fault)
    );

    always #20 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stepper + manual requester model, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            starts.delete();
            ack_cnt = 0; ack_with_start = 0; done_cnt = 0; move_done = 1'b1;
            last_start = -1; min_gap = 1 << 30; fault_cyc = -1;
        end else begin
            if (move_start) begin
                starts.push_back(next_move);
                if (last_start >= 0 && cyc - last_start < min_gap) min_gap = cyc - last_start;
                last_start = cyc;
                move_done  = 1'b0;
                done_cnt   = (stall_done != 0) ? 0 : done_lat;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) move_done = 1'b1;
            end
            if (man_ack) begin
                ack_cnt++;
                if (move_start) ack_with_start++;
            end
            if (fault && fault_cyc < 0) fault_cyc = cyc;
        end
        man_req = (man_posted > ack_cnt);
    end

    typedef struct {
        logic [BATCH_W-1:0] moves;
        int                 exp_count;
        logic               exp_ready;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; batch_valid = 1'b0; pause = 1'b0; man_posted = 0;
        stall_done = 0; man_move = '0; done_lat = DONE_LAT;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic send_batch(input logic [BATCH_W-1:0] b);
        batch_moves = b; batch_valid = 1'b1;
        tick(1);
        batch_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!batch_ready && k < 5000) begin tick(1); k++; end
        check(name, int'(batch_ready), 1);
    endtask

    task automatic wait_done(input int n, input string name);
        int k = 0;
        tick(1);
        while (!(int'(moves_done_count) == n % 256 && !busy && !man_req && batch_ready) && k < 20000) begin
            tick(1); k++;
        end
        check(name, int'(moves_done_count), n % 256);
    endtask

    task automatic check_seq(input string name, input logic [MOVE_W-1:0] exp[$]);
        check({name, " len"}, starts.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check(name, (i < starts.size()) ? int'(starts[i]) : -1, int'(exp[i]));
    endtask

    function automatic logic [BATCH_W-1:0] set_nib(input logic [BATCH_W-1:0] b, input int i,
                                                   input logic [MOVE_W-1:0] c);
        b[i*MOVE_W +: MOVE_W] = c;
        return b;
    endfunction

    initial begin
        vec_t tbl[7];
        logic [BATCH_W-1:0] b;
        logic [MOVE_W-1:0] e[$];
        logic [MOVE_W-1:0] c;
        int k, nvalid;

        b = '0; tbl[0] = '{b, 0, 1'b1};
        b = set_nib('0, 3, 4'hF); b = set_nib(b, 2, 4'h1); b = set_nib(b, 1, 4'hE);
        b = set_nib(b, 0, MOVE_F); tbl[1] = '{b, 1, 1'b1};
        b = '0; for (int i = 0; i < 50; i++) b = set_nib(b, i, MOVE_R);
        tbl[2] = '{b, 50, 1'b0};
        b = '0; for (int i = 0; i < 50; i++) b = set_nib(b, i, 4'(i % 16));
        tbl[3] = '{b, 36, 1'b0};
        b = '0; for (int i = 0; i < 50; i++) b = set_nib(b, i, (i % 3 == 0) ? 4'hE : (i % 3 == 1) ? 4'h1 : 4'hF);
        tbl[4] = '{b, 0, 1'b1};
        b = '0; for (int i = 36; i < 50; i++) b = set_nib(b, i, MOVE_DI);
        tbl[5] = '{b, 14, 1'b1};
        b = '0; for (int i = 0; i < 15; i++) b = set_nib(b, i, MOVE_B);
        tbl[6] = '{b, 15, 1'b0};

        // Reset state
        do_reset();
        check("rst batch_ready", int'(batch_ready), 1);
        check("rst move_start", int'(move_start), 0);
        check("rst man_ack", int'(man_ack), 0);
        check("rst busy", int'(busy), 0);
        check("rst fault", int'(fault), 0);
        check("rst queue_count", int'(queue_count), 0);
        check("rst moves_done", int'(moves_done_count), 0);
        check("rst next_move", int'(next_move), 0);

        // Table: loader filtering and ready threshold, queue held by pause
        for (int t = 0; t < 7; t++) begin
            do_reset();
            pause = 1'b1;
            send_batch(tbl[t].moves);
            check($sformatf("tbl%0d ready while loading", t), int'(batch_ready), 0);
            tick(50);
            check($sformatf("tbl%0d queue_count", t), int'(queue_count), tbl[t].exp_count);
            check($sformatf("tbl%0d batch_ready", t), int'(batch_ready), int'(tbl[t].exp_ready));
            check($sformatf("tbl%0d no start", t), starts.size(), 0);
        end

        // Three queued moves drain in order
        do_reset();
        b = set_nib('0, 2, MOVE_R); b = set_nib(b, 1, MOVE_RI); b = set_nib(b, 0, MOVE_U);
        send_batch(b);
        wait_done(3, "t1 moves_done");
        e.delete(); e.push_back(MOVE_R); e.push_back(MOVE_RI); e.push_back(MOVE_U);
        check_seq("t1 order", e);
        check("t1 queue_count", int'(queue_count), 0);
        check("t1 start spacing", min_gap, DONE_LAT + SETTLE + 2);

        // Round-robin queue vs held manual request
        do_reset();
        b = set_nib('0, 2, MOVE_UI); b = set_nib(b, 1, MOVE_F); b = set_nib(b, 0, MOVE_FI);
        send_batch(b);
        tick(51);
        man_move = MOVE_L; man_posted = 1;
        wait_done(4, "t3 moves_done");
        e.delete(); e.push_back(MOVE_UI); e.push_back(MOVE_L); e.push_back(MOVE_F); e.push_back(MOVE_FI);
        check_seq("t3 order", e);
        check("t3 acks", ack_cnt, 1);
        check("t3 ack with start", ack_with_start, 1);

        // Pause blocks the queue but not manual jogs
        do_reset();
        pause = 1'b1;
        b = '0; for (int i = 0; i < 5; i++) b = set_nib(b, i, 4'(6 - i));
        send_batch(b);
        tick(55);
        check("t4 paused starts", starts.size(), 0);
        check("t4 paused queue", int'(queue_count), 5);
        man_move = MOVE_D; man_posted = 1;
        wait_done(1, "t4 manual done");
        e.delete(); e.push_back(MOVE_D);
        check_seq("t4 manual", e);
        check("t4 acks", ack_cnt, 1);
        check("t4 queue held", int'(queue_count), 5);
        pause = 1'b0;
        wait_done(6, "t4 resume done");
        for (int i = 2; i <= 6; i++) e.push_back(4'(i));
        check_seq("t4 order", e);

        // Watchdog fault
        do_reset();
        stall_done = 1;
        send_batch(set_nib('0, 0, MOVE_LI));
        k = 0;
        while (!fault && k < 1000) begin tick(1); k++; end
        check("t5 fault", int'(fault), 1);
        tick(1);
        check("t5 fault delay", fault_cyc - last_start, TIMEOUT + 3);
        man_move = MOVE_L; man_posted = 1;
        b = '0; for (int i = 0; i < 10; i++) b = set_nib(b, i, MOVE_U);
        send_batch(b);
        tick(55);
        check("t5 no more starts", starts.size(), 1);
        check("t5 no ack", ack_cnt, 0);
        check("t5 loader in fault", int'(queue_count), 10);
        check("t5 busy", int'(busy), 1);
        do_reset();
        check("t5 reset fault", int'(fault), 0);
        check("t5 reset queue", int'(queue_count), 0);
        check("t5 reset busy", int'(busy), 0);

        // Ready threshold at 14/15 and ignored pulse
        do_reset();
        pause = 1'b1;
        b = '0; for (int i = 0; i < 14; i++) b = set_nib(b, i, MOVE_FI);
        send_batch(b);
        tick(50);
        check("t6 count14", int'(queue_count), 14);
        check("t6 ready14", int'(batch_ready), 1);
        send_batch(set_nib('0, 0, MOVE_RI));
        tick(50);
        check("t6 count15", int'(queue_count), 15);
        check("t6 ready15", int'(batch_ready), 0);
        b = '0; for (int i = 0; i < 10; i++) b = set_nib(b, i, MOVE_R);
        send_batch(b);
        tick(55);
        check("t6 ignored batch", int'(queue_count), 15);

        // Random batches vs expected move stream
        do_reset();
        done_lat = 1;
        e.delete();
        for (int bt = 0; bt < 3; bt++) begin
            wait_ready($sformatf("rnd ready %0d", bt));
            b = '0;
            for (int i = 49; i >= 0; i--) begin
                c = 4'($urandom_range(0, 15));
                b = set_nib(b, i, c);
                if (c >= 4'd2 && c <= 4'd13) e.push_back(c);
            end
            send_batch(b);
        end
        wait_done(e.size(), "rnd moves_done");
        check_seq("rnd order", e);
        check("rnd min spacing", min_gap, GAP);

        // Random manual jogs, some invalid
        do_reset();
        e.delete(); nvalid = 0;
        for (int j = 0; j < 8; j++) begin
            c = 4'($urandom_range(0, 15));
            man_move = c;
            if (c >= 4'd2 && c <= 4'd13) begin e.push_back(c); nvalid++; end
            man_posted++;
            tick(1);
            k = 0;
            while ((man_req || busy) && k < 500) begin tick(1); k++; end
            check($sformatf("man %0d served", j), int'(man_req || busy), 0);
        end
        check("man acks", ack_cnt, 8);
        check("man moves_done", int'(moves_done_count), nvalid);
        check_seq("man order", e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Sits between the move producers and the move_to_step stepper driver.
- Accepts 50-slot move batches from the solver path, buffers them in a 64-entry queue, and accepts single manual jog moves from debounced buttons.
- Arbitrates queue vs manual requests and issues one move at a time to the stepper driver using a start/done handshake.
- Adds a post-move settle delay and a watchdog that latches a fault.

Parameters:
- SETTLE_CYCLES, 25000: idle cycles after each completed move (1 ms at 25 MHz).
- TIMEOUT_CYCLES, 25000000: max cycles waiting for move_done before fault (1 s).
- DEPTH, 64: queue depth in moves (power of two, ≥ 50).

Ports:
- clock  in  1  system clock (25 MHz domain).
- reset  in  1  synchronous, active-high reset.
- batch_valid  in  1  one-cycle pulse; batch_moves is valid.
- batch_moves  in  200  50 × 4-bit move codes; nibble 49 [199:196] is first, nibble 0 is last.
- batch_ready  out  1  batch will be accepted this cycle.
- man_req  in  1  level; manual move requested.
- man_move  in  4  manual move code.
- man_ack  out  1  one-cycle pulse; manual request consumed.
- pause  in  1  level; blocks queue dispatch only.
- next_move  out  4  move code to stepper driver.
- move_start  out  1  one-cycle start pulse to stepper driver.
- move_done  in  1  level from stepper driver; low while a move is in progress.
- queue_count  out  7  entries in queue, 0..64.
- moves_done_count  out  8  completed moves; wraps 255→0.
- busy  out  1  dispatch FSM not in IDLE.
- fault  out  1  sticky watchdog fault.

Behaviour:
- Reset values: all outputs 0, except batch_ready = 1 (queue empty, loader idle). Reset also flushes the queue, aborts the loader and clears fault. Reset mid-move drops move_start immediately; the in-flight move is not tracked further.
- Move codes: valid codes are 2..13. Code 0 means an empty slot. Codes 1, 14 and 15 are invalid.
- Loader:
  - batch_ready = loader idle AND queue_count ≤ DEPTH−50.
  - On batch_valid && batch_ready, latch batch_moves, then scan nibble 49 down to 0 at one nibble per cycle (50 cycles).
  - Push valid codes; silently skip 0 and invalid codes.
  - batch_valid while not ready is ignored; no state change.
- Queue: synchronous FIFO. Push and pop in the same cycle leaves count unchanged. Pop only when non-empty; push can never overflow under the batch_ready rule.
- Dispatch FSM states: IDLE, ISSUE, BLANK, WAIT_DONE, SETTLE, FAULT.
- IDLE, candidates:
  - Q = queue non-empty AND !pause.
  - M = man_req.
- IDLE, arbitration:
  - If both Q and M, round-robin: the requester not served last wins; after reset, queue wins first.
  - Winning Q: pop, set next_move = head.
  - Winning M with a valid code: pulse man_ack, set next_move = man_move.
  - Winning M with an invalid code: pulse man_ack, drop the request, stay in IDLE (it counts as "manual served" for round-robin).
  - On issue, go to ISSUE.
- ISSUE: move_start = 1 for exactly this cycle; next_move is held stable from this cycle until leaving WAIT_DONE. Go to BLANK.
- BLANK: 2 cycles during which move_done is ignored (masks stale done). Go to WAIT_DONE; the watchdog counter starts at 0 on entry.
- WAIT_DONE:
  - move_done = 1: increment moves_done_count, go to SETTLE.
  - Counter reaches TIMEOUT_CYCLES−1 without done: set fault, go to FAULT.
- SETTLE: count SETTLE_CYCLES cycles, then return to IDLE. Minimum spacing between move_start pulses is 1 + 2 + 1 + SETTLE_CYCLES + 1 cycles.
- FAULT:
  - Terminal until reset; busy = 1, move_start = 0.
  - The loader keeps accepting batches up to capacity.
  - man_req is not acked.
- pause asserted mid-move does not abort; it takes effect at the next IDLE.
- busy = 0 only in IDLE.

Decomposition:
- Shared package rbot_moves_pkg:
  - Move code constants R=2 … Di=13 and MOVE_NONE=0.
  - Function is_valid_move (codes 2..13).
  - Batch constants: MOVES_PER_BATCH=50, MOVE_W=4.
- One sub-module: move_fifo (DEPTH × 4 sync FIFO with count, push, pop, head output).
- Loader and dispatch FSM stay in move_arbiter.

Test Plan:
1. Batch {…0, R, Ri, U} (nibbles 2..0 = 2, 3, 4; rest 0) with move_done returned 10 cycles after each start → start pulses carry 2, 3, 4 in order; moves_done_count = 3; queue_count ends at 0.
2. Batch with nibbles 0xF, 0x1, 0xE, 0x6 → only F (6) is queued; queue_count = 1 after 50 load cycles.
3. Queue holds 3 moves and man_req is held with man_move = 8 → issue order queue, manual, queue, queue; man_ack pulses once, coincident with IDLE→ISSUE of the manual move.
4. pause = 1 with 5 queued moves → no move_start; a manual request with man_move = 12 is issued and acked; deasserting pause resumes the queue.
5. move_done held low after a start, with TIMEOUT_CYCLES = 100 in the test → fault rises 100 cycles after WAIT_DONE entry; no further starts; reset clears fault and queue.
6. Load 14 moves, then pulse a second batch → batch_ready = 1 only while loader idle and count ≤ 14; a 15-move queue deasserts batch_ready and the pulse is ignored.
